// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle restoring divider, signed/unsigned, one quotient bit per clock
// Four-state FSM: FREE accepts, BYZERO short-circuits divide-by-zero, ON iterates, END holds the result.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [2*WIDTH:0]       work, work_nxt;
  logic [WIDTH-1:0]       divisor, divisor_nxt;
  logic                   sgn_mode, sgn_mode_nxt;
  logic                   sgn_a, sgn_a_nxt;
  logic                   sgn_b, sgn_b_nxt;
  logic                   ready_nxt;
  logic [2*WIDTH-1:0]     result_nxt;

  logic [WIDTH:0]         trial;
  logic [WIDTH-1:0]       mag_a, mag_b;
  logic [WIDTH-1:0]       quo, rem, quo_f, rem_f;

  always_ff @(posedge Clk or posedge Rst_n) begin
    if (Rst_n) begin
      state    <= FREE;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      sgn_mode <= 1'b0;
      sgn_a    <= 1'b0;
      sgn_b    <= 1'b0;
      ready_o  <= 1'b0;
      result_o <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      work     <= work_nxt;
      divisor  <= divisor_nxt;
      sgn_mode <= sgn_mode_nxt;
      sgn_a    <= sgn_a_nxt;
      sgn_b    <= sgn_b_nxt;
      ready_o  <= ready_nxt;
      result_o <= result_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    work_nxt     = work;
    divisor_nxt  = divisor;
    sgn_mode_nxt = sgn_mode;
    sgn_a_nxt    = sgn_a;
    sgn_b_nxt    = sgn_b;
    ready_nxt    = ready_o;
    result_nxt   = result_o;

    // Magnitudes of the raw operands; only meaningful on the accept cycle.
    mag_a = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    mag_b = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    trial = {1'b0, work[2*WIDTH-1:WIDTH]} - {1'b0, divisor};

    quo   = work[WIDTH-1:0];
    rem   = work[2*WIDTH:WIDTH+1];
    quo_f = (sgn_mode && (sgn_a ^ sgn_b)) ? -quo : quo;
    rem_f = (sgn_mode && sgn_a) ? -rem : rem;

    unique case (state)
      FREE: begin
        ready_nxt  = 1'b0;
        result_nxt = '0;
        if (start_i && !annul_i) begin
          sgn_mode_nxt = signed_div_i;
          sgn_a_nxt    = opdata1_i[WIDTH-1];
          sgn_b_nxt    = opdata2_i[WIDTH-1];
          work_nxt     = {{WIDTH{1'b0}}, mag_a, 1'b0};
          divisor_nxt  = mag_b;
          cnt_nxt      = '0;
          state_nxt    = (opdata2_i == '0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        result_nxt = '0;
        if (annul_i) begin
          state_nxt = FREE;
          cnt_nxt   = '0;
          ready_nxt = 1'b0;
        end else begin
          state_nxt = END;
          ready_nxt = 1'b1;
        end
      end
      ON: begin
        if (annul_i) begin
          state_nxt  = FREE;
          cnt_nxt    = '0;
          ready_nxt  = 1'b0;
          result_nxt = '0;
        end else if (cnt == CW'(WIDTH)) begin
          state_nxt  = END;
          ready_nxt  = 1'b1;
          result_nxt = {rem_f, quo_f};
        end else begin
          // Restoring step: subtract only if the partial remainder covers the divisor.
          if (trial[WIDTH]) work_nxt = {work[2*WIDTH-1:0], 1'b0};
          else              work_nxt = {trial[WIDTH-1:0], work[WIDTH-1:0], 1'b1};
          cnt_nxt = cnt + CW'(1);
        end
      end
      END: begin
        if (!start_i) begin
          state_nxt  = FREE;
          ready_nxt  = 1'b0;
          result_nxt = '0;
        end
      end
      default: state_nxt = FREE;
    endcase
  end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - randomized self-checking bench for div_seq against an arithmetic reference
module tb_div_seq;

  localparam int W = 32;

  logic           Clk = 1'b0;
  logic           Rst_n;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic           start_i;
  logic           annul_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;

  int checks   = 0;
  int failures = 0;

  div_seq #(.WIDTH(W)) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Divide magnitudes, then apply the sign rules: quotient truncates toward zero, remainder follows dividend.
  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    if (b == 0) return 64'h0;
    ma = (s && a[31]) ? (32'h0 - a) : a;
    mb = (s && b[31]) ? (32'h0 - b) : b;
    q = ma / mb;
    r = ma % mb;
    if (s && (a[31] ^ b[31])) q = 32'h0 - q;
    if (s && a[31])           r = 32'h0 - r;
    return {r, q};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Entered just after a rising edge with the DUT in FREE; leaves it the same way.
  task automatic do_div(input bit s, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [63:0] exp;
    int edges, exp_lat;
    exp     = ref_div(s, a, b);
    exp_lat = (b == 0) ? 2 : W + 2;
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    edges        = 0;
    while (edges < 100) begin
      tick();
      edges++;
      signed_div_i = 1'($urandom);
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      if (ready_o) break;
      if (edges == 1) check("busy_ready", {63'h0, ready_o}, 64'h0);
    end
    check("latency", 64'(edges), 64'(exp_lat));
    check("result", result_o, exp);
    for (int k = 0; k < hold; k++) begin
      annul_i = 1'($urandom);
      tick();
      check("hold_ready", {63'h0, ready_o}, 64'h1);
      check("hold_result", result_o, exp);
    end
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();
    check("drop_ready", {63'h0, ready_o}, 64'h0);
    check("drop_result", result_o, 64'h0);
  endtask

  initial begin
    logic [31:0] a, b;
    bit s;
    int sel;

    Rst_n        = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    tick();
    tick();
    check("reset_ready", {63'h0, ready_o}, 64'h0);
    check("reset_result", result_o, 64'h0);
    Rst_n = 1'b0;
    tick();

    do_div(1'b0, 32'd100, 32'd7, 0);
    do_div(1'b0, 32'd100, 32'd7, 3);
    do_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1);
    do_div(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 0);
    do_div(1'b0, 32'h1234_5678, 32'h0, 2);
    do_div(1'b1, 32'h8765_4321, 32'h0, 0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'h1, 0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_div(1'b1, 32'h8000_0000, 32'h0000_0001, 0);

    for (int n = 0; n < 40; n++) begin
      s   = 1'($urandom);
      sel = $urandom_range(0, 9);
      a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
      if (sel == 0)      b = 32'h0;
      else if (sel < 4)  b = 32'($urandom_range(1, 15)) * (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h1);
      else               b = $urandom;
      do_div(s, a, b, $urandom_range(0, 2));
    end

    // Flush at iteration 10 of a real division.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (11) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    check("annul_on_ready", {63'h0, ready_o}, 64'h0);
    check("annul_on_result", result_o, 64'h0);
    annul_i = 1'b0;
    repeat (3) tick();
    check("annul_idle_ready", {63'h0, ready_o}, 64'h0);
    do_div(1'b0, 32'd100, 32'd7, 0);

    // Flush while in BYZERO.
    opdata1_i = 32'd55;
    opdata2_i = 32'd0;
    start_i   = 1'b1;
    tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    check("annul_bz_ready", {63'h0, ready_o}, 64'h0);
    annul_i = 1'b0;
    tick();
    check("annul_bz_idle", {63'h0, ready_o}, 64'h0);

    // Annul with start held high in FREE must not start anything.
    opdata1_i = 32'd9;
    opdata2_i = 32'd0;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    repeat (3) tick();
    check("annul_free_ready", {63'h0, ready_o}, 64'h0);
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();

    // Asynchronous reset while a result is being held.
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    repeat (W + 2) tick();
    check("pre_reset_ready", {63'h0, ready_o}, 64'h1);
    #3 Rst_n = 1'b1;
    #1;
    check("async_rst_end_ready", {63'h0, ready_o}, 64'h0);
    check("async_rst_end_result", result_o, 64'h0);
    start_i = 1'b0;
    tick();
    Rst_n = 1'b0;
    tick();

    // Asynchronous reset at iteration 20.
    start_i = 1'b1;
    repeat (21) tick();
    #3 Rst_n = 1'b1;
    #1;
    check("async_rst_on_ready", {63'h0, ready_o}, 64'h0);
    check("async_rst_on_result", result_o, 64'h0);
    start_i = 1'b0;
    tick();
    Rst_n = 1'b0;
    tick();
    do_div(1'b0, 32'd9, 32'd3, 0);
    check("post_reset_9_3", ref_div(1'b0, 32'd9, 32'd3), 64'h0000_0000_0000_0003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand width; the quotient and remainder are each WIDTH bits.
REQ-002 Clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Rst_n  input  1  reset; asynchronous and active-high despite the name (1 = reset).
REQ-004 signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled only when a start is accepted.
REQ-005 opdata1_i  input  WIDTH  dividend; sampled only when a start is accepted.
REQ-006 opdata2_i  input  WIDTH  divisor; sampled only when a start is accepted.
REQ-007 start_i  input  1  request from EX; held high until ready_o is seen, then dropped.
REQ-008 annul_i  input  1  cancel the current/pending division (flush); wins over start_i.
REQ-009 result_o  output  2*WIDTH  {remainder, quotient}; valid only while ready_o=1.
REQ-010 ready_o  output  1  result valid, registered.

Function
REQ-011 The FSM SHALL have exactly four states: FREE, BYZERO, ON, END.
REQ-012 In FREE with start_i=1 and annul_i=0, the block SHALL accept: divisor==0 -> BYZERO; otherwise -> ON, iteration counter=0.
REQ-013 On accept, the block SHALL capture signed_div_i, sign(opdata1_i) and sign(opdata2_i), and form magnitudes: two's-complement negation when signed and MSB=1, raw value otherwise.
REQ-014 On accept, the working register (2*WIDTH+1 bits) SHALL load {WIDTH zeros, |dividend|, 1'b0}, and |divisor| SHALL be latched.
REQ-015 Each ON cycle SHALL do one restoring step: trial = {0, work[2W-1:W]} - {0, divisor}.
REQ-016 Step, trial MSB=1: work <= work<<1.
REQ-017 Step, trial MSB=0: work <= {trial[W-1:0], work[W-1:0], 1'b1}.
REQ-018 Step, both cases: counter++.
REQ-019 In ON with counter==WIDTH, the block SHALL go to END and register result_o.
REQ-020 result_o quotient field SHALL be work[W-1:0], negated when signed and dividend sign XOR divisor sign = 1.
REQ-021 result_o remainder field SHALL be work[2W:W+1], negated when signed and dividend sign = 1.
REQ-022 Latency: with start accepted at edge 1, ready_o SHALL rise after edge WIDTH+2 (34 for WIDTH=32).
REQ-023 BYZERO SHALL go to END on the next edge with result_o=0 (ready_o rises after edge 2).
REQ-024 In END, ready_o=1 and result_o SHALL hold while start_i=1.
REQ-025 In END with start_i=0, the next edge SHALL give FREE, ready_o=0, result_o=0.
REQ-026 annul_i=1 in ON or BYZERO SHALL return to FREE on the next edge, with ready_o=0, result_o=0 and the counter cleared.
REQ-027 annul_i in END SHALL be ignored; the normal start_i=0 exit applies.
REQ-028 Input changes on opdata*/signed_div_i after accept SHALL NOT affect the result.
REQ-029 A new start SHALL be accepted only from FREE; back-to-back divisions therefore require start_i low for at least one cycle in END.
REQ-030 Signed overflow (most-negative / -1) SHALL produce the natural truncated quotient with no exception flag.

Reset
REQ-031 Rst_n=1 SHALL immediately, without waiting for a clock edge, force the following:
REQ-032 state=FREE, counter=0, work=0, latched divisor=0 and latched signs=0.
REQ-033 ready_o=0 (DivResNoReady) and result_o=0.
REQ-034 A reset mid-operation SHALL abandon the division; after release, the block SHALL accept a new start normally.

Verification
REQ-035 Unsigned 100/7, start held -> ready_o high after edge 34, result_o=0x00000002_0000000E; drop start -> next edge ready_o=0, result_o=0.
REQ-036 Signed -7/2 (0xFFFFFFF9/0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD; signed 7/-2 -> 0x00000001_FFFFFFFD.
REQ-037 Divide by zero (any dividend, divisor 0) -> ready_o high after edge 2, result_o=0.
REQ-038 Unsigned 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF; signed 0x80000000/0xFFFFFFFF -> 0x00000000_80000000.
REQ-039 annul_i pulsed at iteration 10 -> FREE next edge, ready_o stays 0; a following 100/7 start completes correctly in 34 edges.
REQ-040 Rst_n asserted at iteration 20 between clock edges -> ready_o=0 and result_o=0 immediately; after release, 9/3 gives 0x00000000_00000003.
